mult_div_unit: RTL and testbench

Iterative 32-bit multiply/divide responder for the ALU's MULT/MULTU/DIV/DIVU path. It serves the validIn/validOut handshake that the ALU drives: it latches operands when validIn is seen, computes over about 34 cycles, then pulses validOut with the Hi/Lo results. The ALU holds validIn high and stalls the pipeline until validOut; this block owns the sequencing, sign handling and divide edge cases.

---
 rtl/mdu_pkg.sv | 18 +
 rtl/mdu_cond_neg.sv | 12 +
 rtl/mult_div_unit.sv | 147 ++++++++++++++
 tb/tb_mult_div_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mdu_state_t;

    localparam logic MDU_OP_MUL = 1'b0;
    localparam logic MDU_OP_DIV = 1'b1;

    localparam logic [MDU_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/mdu_cond_neg.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module mdu_cond_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? ('0 - value) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit: fixed 34-cycle latency from the sampling edge to validOut.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             validIn,
    input  logic             op,
    input  logic             sign,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             validOut,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             busy,
    output logic             divZero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_t state, state_next;

    logic [CNT_W-1:0]   cnt;
    logic               op_r;
    logic               neg_res;
    logic               neg_rem;
    logic               b_zero;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_sub;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    mdu_cond_neg #(.W(WIDTH)) u_neg_a (
        .value(SrcA), .negate(sign & SrcA[WIDTH-1]), .result(a_mag)
    );
    mdu_cond_neg #(.W(WIDTH)) u_neg_b (
        .value(SrcB), .negate(sign & SrcB[WIDTH-1]), .result(b_mag)
    );
    mdu_cond_neg #(.W(2*WIDTH)) u_neg_prod (
        .value(acc), .negate(neg_res), .result(prod_fix)
    );
    mdu_cond_neg #(.W(WIDTH)) u_neg_quot (
        .value(acc[WIDTH-1:0]), .negate(neg_res), .result(quot_fix)
    );
    mdu_cond_neg #(.W(WIDTH)) u_neg_rem (
        .value(rem[WIDTH-1:0]), .negate(neg_rem), .result(rem_fix)
    );

    // Multiply keeps the multiplier in acc's low half and shifts the partial product in from the top;
    // divide keeps the dividend/quotient in acc's low half and shifts quotient bits in at the bottom.
    assign mul_addend = acc[0] ? opnd : '0;
    assign mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    assign div_trial  = {rem[WIDTH-1:0], acc[WIDTH-1]};
    assign div_sub    = {rem, acc[WIDTH-1]} - {2'b00, opnd};

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (validIn) state_next = CALC;
            CALC: if (cnt == CNT_LAST) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_r     <= MDU_OP_MUL;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            b_zero   <= 1'b0;
            a_raw    <= '0;
            opnd     <= '0;
            acc      <= '0;
            rem      <= '0;
            Hi       <= '0;
            Lo       <= '0;
            validOut <= 1'b0;
            divZero  <= 1'b0;
        end else begin
            validOut <= (state == FIX);
            divZero  <= (state == FIX) && (op_r == MDU_OP_DIV) && b_zero;
            case (state)
                IDLE: begin
                    if (validIn) begin
                        cnt     <= '0;
                        op_r    <= op;
                        neg_res <= sign & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                        neg_rem <= sign & SrcA[WIDTH-1];
                        b_zero  <= (SrcB == '0);
                        a_raw   <= SrcA;
                        rem     <= '0;
                        if (op == MDU_OP_DIV) begin
                            opnd <= b_mag;
                            acc  <= {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            opnd <= a_mag;
                            acc  <= {{WIDTH{1'b0}}, b_mag};
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (op_r == MDU_OP_MUL) begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end else begin
                        rem <= div_sub[WIDTH+1] ? div_trial : div_sub[WIDTH:0];
                        acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~div_sub[WIDTH+1]};
                    end
                end
                FIX: begin
                    if (op_r == MDU_OP_MUL) begin
                        {Hi, Lo} <= prod_fix;
                    end else if (b_zero) begin
                        Hi <= a_raw;
                        Lo <= DIV0_QUOTIENT;
                    end else begin
                        Hi <= rem_fix;
                        Lo <= quot_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: result values, fixed latency, pulse shape and multi-cycle corners.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        validIn;
    logic        op;
    logic        sign;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        validOut;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        busy;
    logic        divZero;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .validIn(validIn), .op(op), .sign(sign),
        .SrcA(SrcA), .SrcB(SrcB), .validOut(validOut), .Hi(Hi), .Lo(Lo),
        .busy(busy), .divZero(divZero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic        sign;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[13];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic o, input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] hi, output logic [31:0] lo,
                         output logic dz, output logic bsy, output logic after_v, output logic after_b);
        @(negedge clk);
        validIn = 1'b1; op = o; sign = s; SrcA = a; SrcB = b;
        @(posedge clk);
        #1;
        validIn = 1'b0; SrcA = $urandom; SrcB = $urandom;
        lat = 0; hi = '0; lo = '0; dz = 1'b0; bsy = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (validOut) begin
                lat = n; hi = Hi; lo = Lo; dz = divZero; bsy = busy;
                break;
            end
        end
        @(negedge clk);
        after_v = validOut;
        after_b = busy;
    endtask

    int          lat;
    logic [31:0] r_hi, r_lo;
    logic        r_dz, r_bsy, r_av, r_ab;

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};

        rst_n = 1'b0; validIn = 1'b0; op = 1'b0; sign = 1'b0; SrcA = '0; SrcB = '0;
        #12;
        check("reset validOut", {31'b0, validOut}, 32'd0);
        check("reset busy",     {31'b0, busy},     32'd0);
        check("reset divZero",  {31'b0, divZero},  32'd0);
        check("reset Hi",       Hi,                32'd0);
        check("reset Lo",       Lo,                32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].op, vecs[i].sign, vecs[i].a, vecs[i].b, lat, r_hi, r_lo, r_dz, r_bsy, r_av, r_ab);
            check($sformatf("v%0d latency", i), 32'(lat), 32'd34);
            check($sformatf("v%0d Hi", i), r_hi, vecs[i].hi);
            check($sformatf("v%0d Lo", i), r_lo, vecs[i].lo);
            check($sformatf("v%0d divZero", i), {31'b0, r_dz}, {31'b0, vecs[i].dz});
            check($sformatf("v%0d busy in DONE", i), {31'b0, r_bsy}, 32'd1);
            check($sformatf("v%0d pulse end", i), {31'b0, r_av}, 32'd0);
            check($sformatf("v%0d idle busy", i), {31'b0, r_ab}, 32'd0);
        end

        // validIn held high across two back-to-back requests, operands scrambled while busy
        begin
            int          first_v = 0;
            int          second_v = 0;
            int          hold_bad = 0;
            logic [31:0] hi1 = '0, lo1 = '0, hi2 = '0, lo2 = '0;
            logic [31:0] exp_hi, exp_lo;
            @(negedge clk);
            validIn = 1'b1; op = 1'b0; sign = 1'b0; SrcA = 32'h00010001; SrcB = 32'h00000003;
            @(posedge clk);
            for (int n = 1; n <= 80; n++) begin
                @(negedge clk);
                if (validOut && first_v == 0) begin
                    first_v = n; hi1 = Hi; lo1 = Lo;
                end else if (validOut && second_v == 0) begin
                    second_v = n; hi2 = Hi; lo2 = Lo;
                end
                if (first_v == 0) begin
                    exp_hi = vecs[12].hi; exp_lo = vecs[12].lo;
                end else if (second_v == 0) begin
                    exp_hi = 32'h00000000; exp_lo = 32'h00030003;
                end else begin
                    exp_hi = 32'h00000000; exp_lo = 32'd42;
                end
                if (Hi !== exp_hi || Lo !== exp_lo) hold_bad++;
                if (n < 34) begin
                    SrcA = $urandom; SrcB = $urandom;
                end else if (n == 34) begin
                    SrcA = 32'd7; SrcB = 32'd6;
                end else if (n == 36) begin
                    validIn = 1'b0; SrcA = $urandom; SrcB = $urandom;
                end
            end
            check("held latency",     32'(first_v),  32'd34);
            check("held Hi",          hi1,           32'h00000000);
            check("held Lo",          lo1,           32'h00030003);
            check("next op validOut", 32'(second_v), 32'd69);
            check("next op Lo",       lo2,           32'd42);
            check("next op Hi",       hi2,           32'd0);
            check("Hi/Lo hold",       32'(hold_bad), 32'd0);
        end

        // asynchronous reset at CALC count 10, then a clean operation
        @(negedge clk);
        validIn = 1'b1; op = 1'b0; sign = 1'b0; SrcA = 32'hFFFFFFFF; SrcB = 32'h00000002;
        @(posedge clk);
        #1;
        validIn = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        check("pre-abort busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort validOut", {31'b0, validOut}, 32'd0);
        check("abort busy",     {31'b0, busy},     32'd0);
        check("abort Hi",       Hi,                32'd0);
        check("abort Lo",       Lo,                32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b0, 1'b0, 32'd3, 32'd5, lat, r_hi, r_lo, r_dz, r_bsy, r_av, r_ab);
        check("post-reset latency", 32'(lat), 32'd34);
        check("post-reset Lo",      r_lo,     32'd15);
        check("post-reset Hi",      r_hi,     32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
